bitty_exec_ctrl: RTL
====================

# bitty_exec_ctrl

Execution/control stage of the bitty core, directly downstream of the instruction fetch unit. It accepts the fetched 16-bit instruction when the fetch stage raises `run_core` and runs it through a small multi-cycle FSM. It owns the 8×16 register file and the ALU. It drives the shared data-memory port (address mux select, write enable, write data) and returns `done` plus the last ALU result, which the fetch stage uses for PC update and branch resolution.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `run_core` in 1: from fetch; `instr` is valid and should be executed.
- `instr` in 16: fetched instruction.
- `memory_out` in 16: combinational read data from the shared memory.
- `done` out 1: one-cycle pulse; the instruction has retired.
- `last_alu_result` out 16: registered result of the most recent ALU op.
- `en_memory_inst` out 1: selects `memory_addr` onto the memory address bus.
- `en_memory_write` out 1: memory write strobe.
- `memory_addr` out 16: data-memory address.
- `data_to_memory` out 16: store data.

## Operation
- Encoding, `instr[1:0]` = format:
  - 00 R: rx=[15:13], ry=[12:10], alu_sel=[4:2]; rx ← rx op ry.
  - 01 I: rx=[15:13], imm=[12:5] zero-extended to 16; rx ← rx op imm.
  - 10 branch: no register or ALU effect; retire only.
  - 11 LS: rx=[15:13], ry=[12:10], [2]=0 load (rx ← mem[ry]), [2]=1 store (mem[ry] ← rx).
  - `16'h0000` is NOP: no write, retire only.
- ALU, all 16-bit, results truncated to 16 bits:
  - 000 add, 001 sub (wraps), 010 and, 011 or, 100 xor.
  - 101 shl by b[3:0], 110 logical shr by b[3:0].
  - 111 cmp: 0 if a==b, 1 if a>b, 2 if a<b (unsigned).
- FSM states:
  - IDLE: on `run_core`, latch `instr` into IR and go to EXEC.
  - EXEC: R/I compute, write rx, update `last_alu_result`, go to DONE. LS goes to MEM. Branch/NOP goes to DONE.
  - MEM: `en_memory_inst`=1, `memory_addr`=R[ry]. Load: R[rx] ← `memory_out` at the clock edge. Store: `en_memory_write`=1, `data_to_memory`=R[rx]. Go to DONE.
  - DONE: `done`=1, go to IDLE.
- Memory outputs are combinational from state and IR/registers. They are zero outside MEM.
- `last_alu_result` changes only on R/I ops. Loads, stores, branches and NOPs leave it unchanged.
- `run_core` outside IDLE is ignored.
- r0 is an ordinary register, writable.

## Timing
- Reset (synchronous) forces:
  - state IDLE, IR=0, all R[0..7]=0, `last_alu_result`=0;
  - `done`=0, `en_memory_inst`=0, `en_memory_write`=0, `memory_addr`=0, `data_to_memory`=0.
- Reset during EXEC or MEM aborts the instruction. A write on that same edge is suppressed; reset has priority.
- Edge counting, with `run_core` sampled high at edge N:
  - R/I/branch/NOP: `done` is high in the cycle after edge N+1, so it is seen at edge N+2.
  - LS: MEM occupies the cycle after edge N+1; `done` is seen at edge N+3.
- `done` is exactly one cycle wide. The next `run_core` is accepted no earlier than the edge after DONE.
- A register written by instruction k is visible to instruction k+1 (no hazards; single issue).

## Configuration
- Macro `BITTY_CMP_EN`:
  - Defined: alu_sel 111 performs cmp as specified.
  - Undefined: alu_sel 111 yields result 0. It still writes rx and updates `last_alu_result`.

## Test plan
- Reset, then I-type add r1 ← 0 + 8'hFF (instr 16'h3FE1) → R1=16'h00FF; `last_alu_result`=16'h00FF; `done` pulses 2 edges after `run_core`.
- R1=16'hFFFF, R2=1, R-type add r1,r2 → R1=16'h0000 (wrap).
- R-type sub r1,r2 with R1=0, R2=1 → R1=16'hFFFF.
- Store with R3=16'h0010, R4=16'hBEEF:
  - MEM cycle shows `en_memory_inst`=1, `en_memory_write`=1, `memory_addr`=16'h0010, `data_to_memory`=16'hBEEF.
  - `done` 3 edges after `run_core`; `last_alu_result` unchanged.
- Load from 16'h0010 with `memory_out`=16'h1234 → R5=16'h1234. `en_memory_write` stays 0 throughout.
- cmp with R1=5, R2=9 → `last_alu_result`=2 with `BITTY_CMP_EN`, 0 without.
- Reset asserted in EXEC:
  - no register update;
  - all outputs 0 next cycle;
  - `run_core` held high during EXEC/DONE is not re-latched.

Source files
------------

// File: rtl/bitty_exec_ctrl.sv
// bitty execution/control stage: instruction register, 8x16 register file, ALU and data-memory port sequencing.
// Optional feature macro: BITTY_CMP_EN (alu_sel 111 unsigned compare; otherwise that op yields 0).
module bitty_exec_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        run_core,
   input  logic [15:0] instr,
   input  logic [15:0] memory_out,
   output logic        done,
   output logic [15:0] last_alu_result,
   output logic        en_memory_inst,
   output logic        en_memory_write,
   output logic [15:0] memory_addr,
   output logic [15:0] data_to_memory
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_DONE} state_t;

   state_t      state_reg, state_next;
   logic [15:0] ir_reg, ir_next;
   logic [15:0] last_alu_reg, last_alu_next;
   logic [15:0] rf_reg [8];

   logic [1:0]  fmt;
   logic [2:0]  rx_idx, ry_idx, alu_sel;
   logic        is_nop;
   logic [15:0] op_a, op_b, alu_result, wr_data;
   logic        alu_we, load_we;
   logic [7:0]  wen;

   assign fmt     = ir_reg[1:0];
   assign rx_idx  = ir_reg[15:13];
   assign ry_idx  = ir_reg[12:10];
   assign alu_sel = ir_reg[4:2];
   assign is_nop  = (ir_reg == 16'h0000);

   // I-format replaces ry with the zero-extended 8-bit immediate
   assign op_a = rf_reg[rx_idx];
   assign op_b = (fmt == 2'b01) ? {8'h00, ir_reg[12:5]} : rf_reg[ry_idx];

   always_comb begin
      alu_result = 16'h0000;
      case (alu_sel)
         3'b000: alu_result = op_a + op_b;
         3'b001: alu_result = op_a - op_b;
         3'b010: alu_result = op_a & op_b;
         3'b011: alu_result = op_a | op_b;
         3'b100: alu_result = op_a ^ op_b;
         3'b101: alu_result = op_a << op_b[3:0];
         3'b110: alu_result = op_a >> op_b[3:0];
         default: begin
`ifdef BITTY_CMP_EN
            if (op_a == op_b)     alu_result = 16'd0;
            else if (op_a > op_b) alu_result = 16'd1;
            else                  alu_result = 16'd2;
`else
            alu_result = 16'h0000;
`endif
         end
      endcase
   end

   // Only R/I formats write through the ALU; only loads write from memory
   assign alu_we  = (state_reg == S_EXEC) && !is_nop && !fmt[1];
   assign load_we = (state_reg == S_MEM) && !ir_reg[2];
   assign wr_data = alu_we ? alu_result : memory_out;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_wen
         assign wen[gi] = (alu_we || load_we) && (rx_idx == 3'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         ir_reg       <= 16'h0000;
         last_alu_reg <= 16'h0000;
         for (int i = 0; i < 8; i++) rf_reg[i] <= 16'h0000;
      end else begin
         state_reg    <= state_next;
         ir_reg       <= ir_next;
         last_alu_reg <= last_alu_next;
         for (int i = 0; i < 8; i++) begin
            if (wen[i]) rf_reg[i] <= wr_data;
         end
      end
   end

   always_comb begin
      state_next      = state_reg;
      ir_next         = ir_reg;
      last_alu_next   = last_alu_reg;
      done            = 1'b0;
      en_memory_inst  = 1'b0;
      en_memory_write = 1'b0;
      memory_addr     = 16'h0000;
      data_to_memory  = 16'h0000;
      case (state_reg)
         S_IDLE: begin
            if (run_core) begin
               ir_next    = instr;
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (alu_we) last_alu_next = alu_result;
            state_next = (!is_nop && fmt == 2'b11) ? S_MEM : S_DONE;
         end
         S_MEM: begin
            en_memory_inst = 1'b1;
            memory_addr    = rf_reg[ry_idx];
            if (ir_reg[2]) begin
               en_memory_write = 1'b1;
               data_to_memory  = rf_reg[rx_idx];
            end
            state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign last_alu_result = last_alu_reg;

endmodule
